// File: rtl/reg_writeback_if.sv
// MEM -> WB handshake and load-return bundle for reg_writeback.
// The master side (MEM stage / data memory) drives the instruction and
// load-return fields. The slave side (write-back stage) returns In_ready.
interface reg_writeback_if #(
   parameter int W  = 32,
   parameter int RA = 5
);
   logic          In_valid;
   logic          In_ready;
   logic          In_reg_write;
   logic [RA-1:0] In_dst;
   logic [1:0]    In_sel;
   logic [W-1:0]  In_alu;
   logic [W-1:0]  In_pc4;
   logic          Ld_valid;
   logic [W-1:0]  Ld_data;

   modport master (
      output In_valid, In_reg_write, In_dst, In_sel, In_alu, In_pc4,
      output Ld_valid, Ld_data,
      input  In_ready
   );

   modport slave (
      input  In_valid, In_reg_write, In_dst, In_sel, In_alu, In_pc4,
      input  Ld_valid, Ld_data,
      output In_ready
   );
endinterface

// File: rtl/reg_writeback.sv
// reg_writeback: MIPS write-back stage owning the register-file write port.
// Selects ALU / PC+4 results immediately, or waits in WAIT_LD for load data.
// Register-file outputs are registered; $0 writes are always suppressed.
// Optional feature macro: WB_BYPASS_EN adds Byp_valid/Byp_reg/Byp_data,
// combinational copies of the registered write port for decode forwarding.
module reg_writeback #(
   parameter int W  = 32,
   parameter int RA = 5
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   reg_writeback_if.slave        mem,
   input  logic                  Flush,
   output logic                  Reg_write,
   output logic [RA-1:0]         Write_reg,
   output logic [W-1:0]          Write_data,
   output logic                  Pend_valid,
   output logic [RA-1:0]         Pend_reg
`ifdef WB_BYPASS_EN
   ,
   output logic                  Byp_valid,
   output logic [RA-1:0]         Byp_reg,
   output logic [W-1:0]          Byp_data
`endif
);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      WAIT_LD = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [RA-1:0] dst_q, dst_d;            // destination of outstanding load
   logic          ld_we_q, ld_we_d;        // latched In_reg_write of that load
   logic          reg_write_q, reg_write_d;
   logic [RA-1:0] write_reg_q, write_reg_d;
   logic [W-1:0]  write_data_q, write_data_d;

   logic          in_ready_s;
   logic          accept_s;
   logic [W-1:0]  result_s;

   assign in_ready_s = (state_q == IDLE) && !Flush;
   assign accept_s   = mem.In_valid && in_ready_s;
   // 2'b11 is treated as an ALU result, so only 2'b10 picks PC+4.
   assign result_s   = (mem.In_sel == 2'b10) ? mem.In_pc4 : mem.In_alu;

   // Next-state and write-port decode; address/data only move on a real write.
   always_comb begin
      state_d      = state_q;
      dst_d        = dst_q;
      ld_we_d      = ld_we_q;
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               if (mem.In_sel == 2'b01) begin
                  state_d = WAIT_LD;
                  dst_d   = mem.In_dst;
                  ld_we_d = mem.In_reg_write;
               end else if (mem.In_reg_write && (mem.In_dst != {RA{1'b0}})) begin
                  reg_write_d  = 1'b1;
                  write_reg_d  = mem.In_dst;
                  write_data_d = result_s;
               end else begin
                  reg_write_d = 1'b0;
               end
            end else begin
               // Ld_valid while idle is ignored.
               state_d = IDLE;
            end
         end
         WAIT_LD: begin
            if (Flush) begin
               // Flush wins even over a coincident Ld_valid.
               state_d = IDLE;
            end else if (mem.Ld_valid) begin
               state_d = IDLE;
               if (ld_we_q && (dst_q != {RA{1'b0}})) begin
                  reg_write_d  = 1'b1;
                  write_reg_d  = dst_q;
                  write_data_d = mem.Ld_data;
               end else begin
                  reg_write_d = 1'b0;
               end
            end else begin
               state_d = WAIT_LD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and register-file write port registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         dst_q        <= {RA{1'b0}};
         ld_we_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= {RA{1'b0}};
         write_data_q <= {W{1'b0}};
      end else begin
         state_q      <= state_d;
         dst_q        <= dst_d;
         ld_we_q      <= ld_we_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign mem.In_ready = in_ready_s;
   assign Reg_write    = reg_write_q;
   assign Write_reg    = write_reg_q;
   assign Write_data   = write_data_q;
   assign Pend_valid   = (state_q == WAIT_LD);
   assign Pend_reg     = dst_q;

`ifdef WB_BYPASS_EN
   // The register file reads asynchronously, so decode forwards the value
   // being written in this cycle.
   assign Byp_valid = reg_write_q;
   assign Byp_reg   = write_reg_q;
   assign Byp_data  = write_data_q;
`endif

endmodule
